mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle tying the fetch and data requestors and the shared RAM port to the arbiter.
// The arbiter takes the master view; the surrounding CPU/RAM side takes the slave view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;

    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ren;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_busy;

    logic              err;

    // Handshake: i_req / d_ren / d_wen stay high until the matching one-cycle
    // x_ready pulse; on the RAM side a strobe completes in the cycle ram_busy is low.
    modport master (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_busy,
        output i_ready, i_rdata, d_ready, d_rdata, ram_addr, ram_wdata, ram_ren, ram_wen, err
    );

    modport slave (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_busy,
        input  i_ready, i_rdata, d_ready, d_rdata, ram_addr, ram_wdata, ram_ren, ram_wen, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one RAM port; data has fixed priority.
// Optional watchdog on ram_busy stalls is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.master  bus,
    output logic [1:0]     state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] DEAD_WORD = DATA_W'(32'hDEADBEEF);

    state_t            state;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ren_q;
    logic              wen_q;
    logic              i_ready_q;
    logic              d_ready_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              d_want;
    logic              i_want;
    logic              expire;
    logic              done;

    // A port whose ready is pulsing this cycle is still showing its old request.
    assign d_want = (bus.d_ren | bus.d_wen) & ~d_ready_q;
    assign i_want = bus.i_req & ~i_ready_q;
    assign done   = ~bus.ram_busy | expire;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    assign expire = bus.ram_busy && (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Counter rests at zero in IDLE, so it starts from zero on every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (bus.ram_busy && !expire) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
    assign bus.err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_want) begin
                        // A simultaneous read+write request is serviced as a write.
                        state   <= GRANT_D;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                        op_wr   <= bus.d_wen;
                        wen_q   <= bus.d_wen;
                        ren_q   <= ~bus.d_wen;
                    end else if (i_want) begin
                        state  <= GRANT_I;
                        addr_q <= bus.i_addr;
                        op_wr  <= 1'b0;
                        ren_q  <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (done) begin
                        state     <= IDLE;
                        ren_q     <= 1'b0;
                        i_ready_q <= 1'b1;
                        i_rdata_q <= expire ? DEAD_WORD : bus.ram_rdata;
                    end
                end
                GRANT_D: begin
                    if (done) begin
                        state     <= IDLE;
                        ren_q     <= 1'b0;
                        wen_q     <= 1'b0;
                        d_ready_q <= 1'b1;
                        if (!op_wr) begin
                            d_rdata_q <= expire ? DEAD_WORD : bus.ram_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ren_q <= 1'b0;
                    wen_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_ren   = ren_q;
    assign bus.ram_wen   = wen_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-table bench for mem_arbiter: each row is one clock of inputs plus the outputs
// expected in that same cycle. Define ARB_TIMEOUT_EN to also cover the watchdog.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          ren;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          irdy;
        logic [DW-1:0] irdata;
        logic          drdy;
        logic [DW-1:0] drdata;
        logic          err;
    } obs_t;

    typedef struct {
        logic          rst;
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_ren;
        logic          d_wen;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic          busy;
        logic [DW-1:0] rdata;
        obs_t          exp;
    } row_t;

    localparam int OBS_W = $bits(obs_t);

`ifdef ARB_TIMEOUT_EN
    localparam int STALL = 3;
`else
    localparam int STALL = 12;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       state_dbg;
    int               checks = 0;
    int               errors = 0;
    logic [OBS_W-1:0] exp_q[$];
    row_t             tbl[30];

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic obs_t ob(logic ren, logic wen, logic [AW-1:0] addr, logic [DW-1:0] wdata,
                                logic irdy, logic [DW-1:0] irdata, logic drdy,
                                logic [DW-1:0] drdata, logic err);
        obs_t o;
        o = '{ren, wen, addr, wdata, irdy, irdata, drdy, drdata, err};
        return o;
    endfunction

    function automatic row_t vr(logic r, logic ireq, logic [AW-1:0] iaddr, logic dren, logic dwen,
                                logic [AW-1:0] daddr, logic [DW-1:0] dwdata, logic busy,
                                logic [DW-1:0] rdata, obs_t e);
        row_t x;
        x.rst = r;     x.i_req = ireq;  x.i_addr = iaddr;
        x.d_ren = dren; x.d_wen = dwen; x.d_addr = daddr; x.d_wdata = dwdata;
        x.busy = busy; x.rdata = rdata; x.exp = e;
        return x;
    endfunction

    task automatic check_obs(input string name);
        obs_t act;
        obs_t exp;
        act = '{bus.ram_ren, bus.ram_wen, bus.ram_addr, bus.ram_wdata, bus.i_ready,
                bus.i_rdata, bus.d_ready, bus.d_rdata, bus.err};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected value queued", name);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got ren=%b wen=%b addr=%h wdata=%h irdy=%b ird=%h drdy=%b drd=%h err=%b, want ren=%b wen=%b addr=%h wdata=%h irdy=%b ird=%h drdy=%b drd=%h err=%b",
                         name, act.ren, act.wen, act.addr, act.wdata, act.irdy, act.irdata,
                         act.drdy, act.drdata, act.err, exp.ren, exp.wen, exp.addr, exp.wdata,
                         exp.irdy, exp.irdata, exp.drdy, exp.drdata, exp.err);
            end
        end
    endtask

    // Drive one cycle of inputs, compare at the falling edge, leave just after the next rise.
    task automatic run_cycle(input row_t r, input string name);
        rst           = r.rst;
        bus.i_req     = r.i_req;
        bus.i_addr    = r.i_addr;
        bus.d_ren     = r.d_ren;
        bus.d_wen     = r.d_wen;
        bus.d_addr    = r.d_addr;
        bus.d_wdata   = r.d_wdata;
        bus.ram_busy  = r.busy;
        bus.ram_rdata = r.rdata;
        exp_q.push_back(r.exp);
        @(negedge clk);
        check_obs(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t z;
        z = ob(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // fetch, no contention
        tbl[0]  = vr(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, z);
        tbl[1]  = vr(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h00500093, ob(1, 0, 32'h10, 0, 0, 0, 0, 0, 0));
        tbl[2]  = vr(0, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 32'h10, 0, 1, 32'h00500093, 0, 0, 0));
        tbl[3]  = vr(0, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 32'h10, 0, 0, 32'h00500093, 0, 0, 0));
        // fetch and store together: store first, fetch granted in the d_ready cycle
        tbl[4]  = vr(0, 1, 32'h24, 0, 1, 32'h200, 32'hA5A5A5A5, 0, 0,
                     ob(0, 0, 32'h10, 0, 0, 32'h00500093, 0, 0, 0));
        tbl[5]  = vr(0, 1, 32'h24, 0, 1, 32'h200, 32'hA5A5A5A5, 0, 32'h11111111,
                     ob(0, 1, 32'h200, 32'hA5A5A5A5, 0, 32'h00500093, 0, 0, 0));
        tbl[6]  = vr(0, 1, 32'h24, 0, 1, 32'h200, 32'hA5A5A5A5, 0, 0,
                     ob(0, 0, 32'h200, 32'hA5A5A5A5, 0, 32'h00500093, 1, 0, 0));
        tbl[7]  = vr(0, 1, 32'h24, 0, 0, 0, 0, 0, 32'hCAFEF00D,
                     ob(1, 0, 32'h24, 32'hA5A5A5A5, 0, 32'h00500093, 0, 0, 0));
        tbl[8]  = vr(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h24, 32'hA5A5A5A5, 1, 32'hCAFEF00D, 0, 0, 0));
        // load with three busy cycles
        tbl[9]  = vr(0, 0, 0, 1, 0, 32'h40, 32'h5555AAAA, 0, 0,
                     ob(0, 0, 32'h24, 32'hA5A5A5A5, 0, 32'hCAFEF00D, 0, 0, 0));
        tbl[10] = vr(0, 0, 0, 1, 0, 32'h40, 32'h5555AAAA, 1, 32'h1,
                     ob(1, 0, 32'h40, 32'h5555AAAA, 0, 32'hCAFEF00D, 0, 0, 0));
        tbl[11] = vr(0, 0, 0, 1, 0, 32'h40, 32'h5555AAAA, 1, 32'h2,
                     ob(1, 0, 32'h40, 32'h5555AAAA, 0, 32'hCAFEF00D, 0, 0, 0));
        tbl[12] = vr(0, 0, 0, 1, 0, 32'h40, 32'h5555AAAA, 1, 32'h3,
                     ob(1, 0, 32'h40, 32'h5555AAAA, 0, 32'hCAFEF00D, 0, 0, 0));
        tbl[13] = vr(0, 0, 0, 1, 0, 32'h40, 32'h5555AAAA, 0, 32'h0BADF00D,
                     ob(1, 0, 32'h40, 32'h5555AAAA, 0, 32'hCAFEF00D, 0, 0, 0));
        tbl[14] = vr(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h40, 32'h5555AAAA, 0, 32'hCAFEF00D, 1, 32'h0BADF00D, 0));
        // fetch held through i_ready: no regrant in the ready cycle
        tbl[15] = vr(0, 1, 32'h80, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h40, 32'h5555AAAA, 0, 32'hCAFEF00D, 0, 32'h0BADF00D, 0));
        tbl[16] = vr(0, 1, 32'h80, 0, 0, 0, 0, 0, 32'h13,
                     ob(1, 0, 32'h80, 32'h5555AAAA, 0, 32'hCAFEF00D, 0, 32'h0BADF00D, 0));
        tbl[17] = vr(0, 1, 32'h84, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h80, 32'h5555AAAA, 1, 32'h13, 0, 32'h0BADF00D, 0));
        tbl[18] = vr(0, 1, 32'h84, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h80, 32'h5555AAAA, 0, 32'h13, 0, 32'h0BADF00D, 0));
        tbl[19] = vr(0, 1, 32'h84, 0, 0, 0, 0, 0, 32'h23,
                     ob(1, 0, 32'h84, 32'h5555AAAA, 0, 32'h13, 0, 32'h0BADF00D, 0));
        tbl[20] = vr(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h84, 32'h5555AAAA, 1, 32'h23, 0, 32'h0BADF00D, 0));
        // read and write together act as a write; d_rdata untouched
        tbl[21] = vr(0, 0, 0, 1, 1, 32'h300, 32'h12345678, 0, 0,
                     ob(0, 0, 32'h84, 32'h5555AAAA, 0, 32'h23, 0, 32'h0BADF00D, 0));
        tbl[22] = vr(0, 0, 0, 1, 1, 32'h300, 32'h12345678, 0, 32'hFFFFFFFF,
                     ob(0, 1, 32'h300, 32'h12345678, 0, 32'h23, 0, 32'h0BADF00D, 0));
        tbl[23] = vr(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h300, 32'h12345678, 0, 32'h23, 1, 32'h0BADF00D, 0));
        // fetch dropped mid-transfer still completes; load arriving during it waits
        tbl[24] = vr(0, 1, 32'h90, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h300, 32'h12345678, 0, 32'h23, 0, 32'h0BADF00D, 0));
        tbl[25] = vr(0, 0, 0, 1, 0, 32'h44, 0, 1, 0,
                     ob(1, 0, 32'h90, 32'h12345678, 0, 32'h23, 0, 32'h0BADF00D, 0));
        tbl[26] = vr(0, 0, 0, 1, 0, 32'h44, 0, 0, 32'h77,
                     ob(1, 0, 32'h90, 32'h12345678, 0, 32'h23, 0, 32'h0BADF00D, 0));
        tbl[27] = vr(0, 0, 0, 1, 0, 32'h44, 0, 0, 0,
                     ob(0, 0, 32'h90, 32'h12345678, 1, 32'h77, 0, 32'h0BADF00D, 0));
        tbl[28] = vr(0, 0, 0, 1, 0, 32'h44, 0, 0, 32'h99,
                     ob(1, 0, 32'h44, 0, 0, 32'h77, 0, 32'h0BADF00D, 0));
        tbl[29] = vr(0, 0, 0, 0, 0, 0, 0, 0, 0,
                     ob(0, 0, 32'h44, 0, 0, 32'h77, 1, 32'h99, 0));

        // reset
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = 0; bus.d_ren = 0; bus.d_wen = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.ram_busy = 0; bus.ram_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        run_cycle(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, z), "reset_state");

        for (int i = 0; i < 30; i++) begin
            run_cycle(tbl[i], $sformatf("row%0d", i));
        end

        // stalled load, then reset while GRANT_D with ram_busy high
        run_cycle(vr(0, 0, 0, 1, 0, 32'h60, 0, 0, 0, ob(0, 0, 32'h44, 0, 0, 32'h77, 0, 32'h99, 0)),
                  "stall_req");
        for (int i = 0; i < STALL; i++) begin
            run_cycle(vr(0, 0, 0, 1, 0, 32'h60, 0, 1, 0,
                         ob(1, 0, 32'h60, 0, 0, 32'h77, 0, 32'h99, 0)), $sformatf("stall%0d", i));
        end
        run_cycle(vr(1, 0, 0, 1, 0, 32'h60, 0, 1, 0, ob(1, 0, 32'h60, 0, 0, 32'h77, 0, 32'h99, 0)),
                  "stall_rst");
        run_cycle(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, z), "abort_zero");
        run_cycle(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, z), "abort_no_ready");

`ifdef ARB_TIMEOUT_EN
        // ram_busy stuck on a load: watchdog returns DEADBEEF after 4 busy cycles
        run_cycle(vr(0, 0, 0, 1, 0, 32'h50, 0, 1, 0, z), "tmo_req");
        for (int i = 0; i < 4; i++) begin
            run_cycle(vr(0, 0, 0, 1, 0, 32'h50, 0, 1, 0, ob(1, 0, 32'h50, 0, 0, 0, 0, 0, 0)),
                      $sformatf("tmo_busy%0d", i));
        end
        run_cycle(vr(0, 0, 0, 0, 0, 0, 0, 1, 0, ob(0, 0, 32'h50, 0, 0, 0, 1, 32'hDEADBEEF, 1)),
                  "tmo_ready");
        run_cycle(vr(0, 0, 0, 0, 0, 0, 0, 1, 0, ob(0, 0, 32'h50, 0, 0, 0, 0, 32'hDEADBEEF, 1)),
                  "tmo_err_sticky");
        run_cycle(vr(1, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 32'h50, 0, 0, 0, 0, 32'hDEADBEEF, 1)),
                  "tmo_rst");
        run_cycle(vr(0, 0, 0, 0, 0, 0, 0, 0, 0, z), "tmo_cleared");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
